// File: rtl/step_ctrl.sv
// rtl/step_ctrl.sv - run/stop/single-step clock-enable sequencer with breakpoint
module step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int AW              = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          btn_run,
  input  logic          btn_step,
  input  logic [3:0]    rate_sel,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  input  logic [AW-1:0] addr,
  input  logic          fetch,
  output logic          cpu_ce,
  output logic [1:0]    state,
  output logic [31:0]   step_count,
  output logic          bp_hit
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is the run button, bit 1 the step button throughout the button path.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    lvl;
  logic [1:0]    lvl_q;
  logic [CW-1:0] db_cnt [2];
  logic [1:0]    ev;
  logic          ev_run;
  logic          ev_step;

  state_t        st;
  logic [15:0]   div;
  logic [15:0]   rate_mask;
  logic          tick;
  logic          skip_bp;
  logic          bp_match;
  logic          issue;

  assign btn_raw = {btn_step, btn_run};

  // Two-flop synchronizer for the asynchronous buttons.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: a new level must stay stable for DEBOUNCE_CYCLES cycles; any bounce back restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      lvl       <= '0;
      lvl_q     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      lvl_q <= lvl;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          lvl[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign ev      = lvl & ~lvl_q;
  assign ev_run  = ev[0];
  assign ev_step = ev[1];

  assign rate_mask = (16'd1 << rate_sel) - 16'd1;
  assign tick      = (div & rate_mask) == 16'd0;
  assign bp_match  = bp_en & fetch & (addr == bp_addr) & ~skip_bp;

  // A pulse is issued on entry to STEP (run wins over a simultaneous step) or on a non-trapping RUN tick.
  assign issue = ((st == ST_STOP || st == ST_BREAK) && ev_step && !ev_run)
              || (st == ST_RUN && !ev_run && tick && !bp_match);

  assign state  = st;
  assign bp_hit = (st == ST_BREAK);

  // Sequencer FSM with registered pulse, step counter, rate divider and breakpoint skip flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= ST_STOP;
      cpu_ce     <= 1'b0;
      step_count <= '0;
      skip_bp    <= 1'b0;
      div        <= '0;
    end else begin
      cpu_ce <= issue;
      div    <= div + 16'd1;
      if (issue) begin
        step_count <= step_count + 32'd1;
      end
      // The skip survives until the resumed instruction has actually been enabled.
      if (cpu_ce) begin
        skip_bp <= 1'b0;
      end
      case (st)
        ST_STOP: begin
          if (ev_run) begin
            st  <= ST_RUN;
            div <= '0;
          end else if (ev_step) begin
            st <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (ev_run) begin
            st      <= ST_STOP;
            skip_bp <= 1'b0;
          end else if (tick && bp_match) begin
            st <= ST_BREAK;
          end
        end
        ST_STEP: begin
          st      <= ST_STOP;
          skip_bp <= 1'b0;
        end
        ST_BREAK: begin
          if (ev_run) begin
            st      <= ST_RUN;
            div     <= '0;
            skip_bp <= 1'b1;
          end else if (ev_step) begin
            st <= ST_STEP;
          end
        end
        default: st <= ST_STOP;
      endcase
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
// tb/tb_step_ctrl.sv - scoreboard bench for step_ctrl
module tb_step_ctrl;

  localparam int D    = 4;
  localparam int LAT  = D + 3;
  localparam int HOLD = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_run = 1'b0;
  logic        btn_step = 1'b0;
  logic [3:0]  rate_sel = 4'd0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'h0;
  logic [31:0] addr;
  logic        fetch;
  logic        cpu_ce;
  logic [1:0]  state;
  logic [31:0] step_count;
  logic        bp_hit;

  step_ctrl #(.DEBOUNCE_CYCLES(D), .AW(32)) dut (
    .clk(clk), .reset(reset), .btn_run(btn_run), .btn_step(btn_step),
    .rate_sel(rate_sel), .bp_en(bp_en), .bp_addr(bp_addr), .addr(addr),
    .fetch(fetch), .cpu_ce(cpu_ce), .state(state), .step_count(step_count),
    .bp_hit(bp_hit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          at;
    logic [31:0] cnt;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] model_cnt = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void expect_pulse(input int at);
    model_cnt = model_cnt + 32'd1;
    exp_q.push_back('{at: at, cnt: model_cnt});
  endfunction

  // Tiny CPU: loops over 0x0C,0x0E,0x10,0x12 and advances whenever it is enabled.
  int   pc_idx = 0;
  logic cpu_on = 1'b0;
  logic cpu_rst = 1'b0;
  always @(negedge clk) begin
    if (cpu_rst) pc_idx = 0;
    else if (cpu_ce && cpu_on) pc_idx = (pc_idx + 1) % 4;
  end
  assign addr  = 32'h0C + 32'(2 * pc_idx);
  assign fetch = cpu_on;

  // Monitor: every cpu_ce pulse must match the head of the expected queue.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      n_vec++;
      n_bad++;
      $display("FAIL missing_pulse: cpu_ce=0 at cycle %0d, expected 1", exp_q[0].at);
      void'(exp_q.pop_front());
    end
    if (cpu_ce) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_pulse: cpu_ce=1 at cycle %0d, expected 0", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e.at));
        check("pulse_step_count", step_count, e.cnt);
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic stop_run();
    int p;
    @(negedge clk);
    p = cyc;
    btn_run = 1'b1;
    wait_until(p + LAT);
    check("stop_state", 32'(state), 32'd0);
    wait_until(p + HOLD);
    btn_run = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic run_at_rate(input int r, input int dur);
    int p, e;
    rate_sel = 4'(r);
    @(negedge clk);
    p = cyc;
    btn_run = 1'b1;
    e = p + LAT;
    for (int n = 0; n < dur; n += (1 << r)) expect_pulse(e + 1 + n);
    wait_until(p + HOLD);
    btn_run = 1'b0;
    wait_until(e + dur);
    rate_sel = 4'd15;
    wait_until(e + dur + 2);
    check("run_pending", 32'(exp_q.size()), 32'd0);
    check("run_state", 32'(state), 32'd1);
    check("run_step_count", step_count, model_cnt);
    stop_run();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p, e, base;

    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_cpu_ce", 32'(cpu_ce), 32'd0);
    check("rst_step_count", step_count, 32'd0);
    check("rst_bp_hit", 32'(bp_hit), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      p = cyc;
      btn_step = 1'b1;
      expect_pulse(p + LAT);
      wait_until(p + HOLD);
      btn_step = 1'b0;
      repeat (12 + $urandom_range(0, 5)) @(negedge clk);
    end
    check("step3_count", step_count, 32'd3);
    check("step3_state", 32'(state), 32'd0);
    check("step3_pending", 32'(exp_q.size()), 32'd0);

    @(negedge clk);
    btn_step = 1'b1;
    repeat (D - 1) @(negedge clk);
    btn_step = 1'b0;
    repeat (15) @(negedge clk);
    check("glitch_count", step_count, 32'd3);

    for (int k = 0; k < 3; k++) begin
      base = int'(model_cnt);
      if (k == 0) run_at_rate(3, 80);
      else run_at_rate($urandom_range(1, 4), $urandom_range(24, 90));
      if (k == 0) check("rate3_pulses", step_count - 32'(base), 32'd10);
    end

    rate_sel = 4'd0;
    @(negedge clk);
    p = cyc;
    btn_run = 1'b1;
    e = p + LAT;
    for (int n = 0; n < 12; n++) expect_pulse(e + 1 + n);
    wait_until(p + 12);
    btn_run = 1'b0;
    wait_until(e + 12);
    reset = 1'b1;
    model_cnt = 32'h0;
    wait_until(e + 14);
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_cpu_ce", 32'(cpu_ce), 32'd0);
    check("midrst_step_count", step_count, 32'd0);
    wait_until(e + 15);
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("postrst_cpu_ce", 32'(cpu_ce), 32'd0);
    end
    check("postrst_state", 32'(state), 32'd0);
    repeat (10) @(negedge clk);

    rate_sel = 4'd15;
    @(negedge clk);
    p = cyc;
    btn_run = 1'b1;
    btn_step = 1'b1;
    e = p + LAT;
    expect_pulse(e + 1);
    wait_until(e + 1);
    check("both_state", 32'(state), 32'd1);
    wait_until(p + HOLD);
    btn_run = 1'b0;
    btn_step = 1'b0;
    repeat (3) @(negedge clk);
    check("both_pending", 32'(exp_q.size()), 32'd0);
    stop_run();

    @(negedge clk);
    force dut.step_count = 32'hFFFF_FFFF;
    #1;
    release dut.step_count;
    model_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    check("preload_count", step_count, 32'hFFFF_FFFF);
    p = cyc;
    btn_step = 1'b1;
    expect_pulse(p + LAT);
    wait_until(p + HOLD);
    btn_step = 1'b0;
    repeat (12) @(negedge clk);
    check("wrap_count", step_count, 32'd0);

    bp_en = 1'b1;
    bp_addr = 32'h10;
    rate_sel = 4'd2;
    cpu_rst = 1'b1;
    repeat (2) @(negedge clk);
    cpu_rst = 1'b0;
    cpu_on = 1'b1;
    @(negedge clk);
    p = cyc;
    btn_run = 1'b1;
    e = p + LAT;
    expect_pulse(e + 1);
    expect_pulse(e + 5);
    wait_until(e + 9);
    check("bp_state", 32'(state), 32'd3);
    check("bp_hit", 32'(bp_hit), 32'd1);
    check("bp_step_count", step_count, 32'd2);
    wait_until(p + HOLD);
    btn_run = 1'b0;
    repeat (12) @(negedge clk);
    check("bp_hold_state", 32'(state), 32'd3);

    @(negedge clk);
    p = cyc;
    btn_run = 1'b1;
    e = p + LAT;
    for (int n = 0; n < 4; n++) expect_pulse(e + 1 + 4 * n);
    wait_until(e + 2);
    check("resume_state", 32'(state), 32'd1);
    check("resume_count", step_count, 32'd3);
    wait_until(p + HOLD);
    btn_run = 1'b0;
    wait_until(e + 17);
    check("retrap_state", 32'(state), 32'd3);
    check("retrap_addr", addr, 32'h10);
    check("retrap_count", step_count, 32'd6);
    repeat (10) @(negedge clk);

    @(negedge clk);
    p = cyc;
    btn_step = 1'b1;
    expect_pulse(p + LAT);
    wait_until(p + HOLD);
    btn_step = 1'b0;
    repeat (12) @(negedge clk);
    check("bpstep_state", 32'(state), 32'd0);
    check("bpstep_bp_hit", 32'(bp_hit), 32'd0);
    check("bpstep_count", step_count, 32'd7);
    check("final_pending", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
